// File: rtl/simd_abs_seq.sv
// ============================================================================
// Module   : simd_abs_seq
// Purpose  : Sequencer that streams a vector operand, one 64-bit word per
//            cycle, through an external simd_unsigned absolute-value datapath
//            and returns registered results with tail byte-enables.
// Options  : SIMD_ABS_SEQ_ZERO_TAIL_EN - when defined, result bytes whose
//            byte-enable is 0 are forced to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simd_abs_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int MIN_WIDTH  = 8,
  parameter int SEW_WIDTH  = $clog2(DATA_WIDTH/MIN_WIDTH)+1,
  parameter int VL_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [VL_WIDTH-1:0]            req_vl_i,
  input  logic [SEW_WIDTH-1:0]           req_sew_i,
  input  logic                           op_valid_i,
  output logic                           op_ready_o,
  input  logic [DATA_WIDTH-1:0]          op_data_i,
  output logic [SEW_WIDTH-1:0]           simd_sew_o,
  output logic [DATA_WIDTH-1:0]          simd_opA_o,
  output logic                           simd_carry_o,
  input  logic [DATA_WIDTH-1:0]          simd_result_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [DATA_WIDTH-1:0]          res_data_o,
  output logic [DATA_WIDTH/MIN_WIDTH-1:0] res_be_o,
  output logic                           res_last_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic                           busy_o
);

  // One byte-enable lane per MIN_WIDTH slice of the word.
  localparam int BE_W = DATA_WIDTH/MIN_WIDTH;
  // Counter width able to hold BE_W itself (elements or lanes per word).
  localparam int CW   = $clog2(BE_W)+1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [SEW_WIDTH-1:0] r_sew;
  logic [VL_WIDTH-1:0]  r_rem;
  logic [CW-1:0]        r_epw;   // elements per word
  logic [CW-1:0]        r_bpe;   // byte-enable lanes per element

  logic                 w_sew_legal;
  logic                 w_start_ok;
  logic [CW-1:0]        w_epw_new;
  logic [CW-1:0]        w_bpe_new;
  logic [VL_WIDTH-1:0]  w_epw_ext;
  logic                 w_is_last;
  logic [CW-1:0]        w_tail_lanes;
  logic [BE_W-1:0]      w_be_new;
  logic [DATA_WIDTH-1:0] w_data_new;
  logic                 w_op_ready;
  logic                 w_req_hs;
  logic                 w_op_hs;
  logic                 w_res_hs;

  // The operand is forwarded untouched; the datapath is used without carry-in.
  assign simd_opA_o   = op_data_i;
  assign simd_carry_o = 1'b0;

  assign w_sew_legal = (req_sew_i != '0) &&
                       ((req_sew_i & (req_sew_i - SEW_WIDTH'(1))) == '0);
  assign w_start_ok  = w_sew_legal && (req_vl_i != '0);

  // One-hot sew bit k selects elements of DATA_WIDTH>>k bits.
  always_comb begin
    w_epw_new = '0;
    w_bpe_new = '0;
    for (int k = 0; k < SEW_WIDTH; k++) begin
      if (req_sew_i[k]) begin
        w_epw_new = CW'(1 << k);
        w_bpe_new = CW'(BE_W >> k);
      end
    end
  end

  // The final beat enables only the lanes of the remaining live elements.
  assign w_epw_ext    = VL_WIDTH'(r_epw);
  assign w_is_last    = (r_rem <= w_epw_ext);
  assign w_tail_lanes = r_rem[CW-1:0] * r_bpe;
  assign w_be_new     = w_is_last ? ~({BE_W{1'b1}} << w_tail_lanes) : {BE_W{1'b1}};

`ifdef SIMD_ABS_SEQ_ZERO_TAIL_EN
  // Blank every result lane that is not enabled.
  always_comb begin
    w_data_new = simd_result_i;
    for (int i = 0; i < BE_W; i++) begin
      if (!w_be_new[i]) w_data_new[i*MIN_WIDTH +: MIN_WIDTH] = '0;
    end
  end
`else
  assign w_data_new = simd_result_i;
`endif

  // Output register is one deep; a new operand may enter while it drains.
  assign w_op_ready = (r_state == RUN) && (!res_valid_o || res_ready_i);
  assign w_req_hs   = req_valid_i && req_ready_o;
  assign w_op_hs    = op_valid_i && w_op_ready;
  assign w_res_hs   = res_valid_o && res_ready_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    op_ready_o   = 1'b0;
    busy_o       = 1'b1;
    simd_sew_o   = r_sew;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        simd_sew_o  = '0;
        if (req_valid_i && w_start_ok) w_state_next = RUN;
      end
      RUN: begin
        op_ready_o = w_op_ready;
        if (w_op_hs && w_is_last) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_res_hs) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request latch, element bookkeeping, result register and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sew       <= '0;
      r_rem       <= '0;
      r_epw       <= '0;
      r_bpe       <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_be_o    <= '0;
      res_last_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (w_req_hs) begin
        r_sew <= req_sew_i;
        r_rem <= req_vl_i;
        r_epw <= w_epw_new;
        r_bpe <= w_bpe_new;
        // Empty or malformed requests finish immediately without beats.
        if (!w_start_ok) begin
          done_o <= 1'b1;
          err_o  <= !w_sew_legal;
        end
      end
      if (w_op_hs) begin
        res_valid_o <= 1'b1;
        res_data_o  <= w_data_new;
        res_be_o    <= w_be_new;
        res_last_o  <= w_is_last;
        r_rem       <= w_is_last ? '0 : (r_rem - w_epw_ext);
      end else if (w_res_hs) begin
        res_valid_o <= 1'b0;
        if (r_state == DRAIN) done_o <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_simd_abs_seq.sv
// ============================================================================
// Module   : tb_simd_abs_seq
// Purpose  : Directed self-checking bench for simd_abs_seq with a behavioural
//            model of the simd_unsigned absolute-value datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simd_abs_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_vl;
  logic [3:0]  req_sew;
  logic        op_valid;
  logic        op_ready;
  logic [63:0] op_data;
  logic [3:0]  simd_sew;
  logic [63:0] simd_opA;
  logic        simd_carry;
  logic [63:0] simd_result;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [7:0]  res_be;
  logic        res_last;
  logic        done;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  simd_abs_seq dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_vl_i     (req_vl),
    .req_sew_i    (req_sew),
    .op_valid_i   (op_valid),
    .op_ready_o   (op_ready),
    .op_data_i    (op_data),
    .simd_sew_o   (simd_sew),
    .simd_opA_o   (simd_opA),
    .simd_carry_o (simd_carry),
    .simd_result_i(simd_result),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_be_o     (res_be),
    .res_last_o   (res_last),
    .done_o       (done),
    .err_o        (err),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-element two's-complement absolute value, element width from one-hot sew.
  function automatic logic [63:0] abs_model(input logic [63:0] a, input logic [3:0] sew);
    int          w;
    logic [63:0] mask;
    logic [63:0] e;
    logic [63:0] r;
    r = '0;
    case (sew)
      4'b0001: w = 64;
      4'b0010: w = 32;
      4'b0100: w = 16;
      4'b1000: w = 8;
      default: return '0;
    endcase
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < 64 / w; i++) begin
      e = (a >> (i * w)) & mask;
      if (e[w-1]) e = (~e + 64'd1) & mask;
      r = r | (e << (i * w));
    end
    return r;
  endfunction

  always_comb simd_result = abs_model(simd_opA, simd_sew);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_vl    = '0;
    req_sew   = '0;
    op_valid  = 1'b0;
    op_data   = '0;
    res_ready = 1'b1;
    step();
    step();

    // ---------------- reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_sew", simd_sew, 0);
    check("rst_done", done, 0);
    check("rst_carry", simd_carry, 0);
    rst = 1'b0;
    step();

    // ---------------- 64-bit single beat
    req_valid = 1'b1; req_sew = 4'b0001; req_vl = 8'd1;
    check("t1_req_ready", req_ready, 1);
    step();                                    // T+1
    req_valid = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_sew", simd_sew, 4'b0001);
    check("t1_op_ready", op_ready, 1);
    op_valid = 1'b1; op_data = 64'hFFFF_FFFF_FFFF_FFFE;
    step();                                    // T+2
    op_valid = 1'b0;
    check("t1_res_valid", res_valid, 1);
    check("t1_data", res_data, 64'h0000_0000_0000_0002);
    check("t1_be", res_be, 8'hFF);
    check("t1_last", res_last, 1);
    check("t1_done_early", done, 0);
    check("t1_drain_op_ready", op_ready, 0);
    step();                                    // T+3
    check("t1_done", done, 1);
    check("t1_err", err, 0);
    check("t1_res_valid_clr", res_valid, 0);
    check("t1_idle", req_ready, 1);
    step();
    check("t1_done_pulse", done, 0);

    // ---------------- 8-bit, vl=10, tail beat
    req_valid = 1'b1; req_sew = 4'b1000; req_vl = 8'd10;
    step();                                    // T+1
    req_valid = 1'b0;
    op_valid = 1'b1; op_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();                                    // T+2
    check("t2_b0_valid", res_valid, 1);
    check("t2_b0_data", res_data, 64'h0101_0101_0101_0101);
    check("t2_b0_be", res_be, 8'hFF);
    check("t2_b0_last", res_last, 0);
    op_data = 64'h0000_0000_0000_81FF;
    #1;
    check("t2_op_ready_pass", op_ready, 1);
    step();                                    // T+3
    op_valid = 1'b0;
    check("t2_b1_data", res_data, 64'h0000_0000_0000_7F01);
    check("t2_b1_be", res_be, 8'h03);
    check("t2_b1_last", res_last, 1);
    step();                                    // T+4
    check("t2_done", done, 1);
    check("t2_err", err, 0);

    // ---------------- 32-bit with a 3-cycle result stall
    req_valid = 1'b1; req_sew = 4'b0010; req_vl = 8'd4;
    step();                                    // T+1
    req_valid = 1'b0;
    op_valid = 1'b1; op_data = 64'hFFFF_FFF0_0000_0005;
    step();                                    // T+2
    check("t3_b0_data", res_data, 64'h0000_0010_0000_0005);
    check("t3_b0_be", res_be, 8'hFF);
    check("t3_b0_last", res_last, 0);
    res_ready = 1'b0; op_data = 64'h0000_0003_FFFF_FFFD;
    #1;
    check("t3_stall_op_ready", op_ready, 0);
    for (int i = 0; i < 2; i++) begin          // T+3, T+4
      step();
      check("t3_hold_valid", res_valid, 1);
      check("t3_hold_data", res_data, 64'h0000_0010_0000_0005);
      check("t3_hold_op_ready", op_ready, 0);
    end
    step();                                    // T+5
    check("t3_hold_data_last", res_data, 64'h0000_0010_0000_0005);
    res_ready = 1'b1;
    #1;
    check("t3_resume_op_ready", op_ready, 1);
    step();                                    // T+6
    op_valid = 1'b0;
    check("t3_b1_valid", res_valid, 1);
    check("t3_b1_data", res_data, 64'h0000_0003_0000_0003);
    check("t3_b1_be", res_be, 8'hFF);
    check("t3_b1_last", res_last, 1);
    step();                                    // T+7
    check("t3_done", done, 1);

    // ---------------- empty request then illegal sew
    req_valid = 1'b1; req_sew = 4'b0100; req_vl = 8'd0;
    step();                                    // T+1
    check("t4_done", done, 1);
    check("t4_err", err, 0);
    check("t4_op_ready", op_ready, 0);
    check("t4_req_ready", req_ready, 1);
    check("t4_busy", busy, 0);
    req_sew = 4'b0110; req_vl = 8'd3;
    step();                                    // T+1 of second
    req_valid = 1'b0;
    check("t4b_done", done, 1);
    check("t4b_err", err, 1);
    check("t4b_req_ready", req_ready, 1);
    step();
    check("t4b_done_pulse", done, 0);
    check("t4b_err_pulse", err, 0);

    // ---------------- reset in RUN after one of three beats
    req_valid = 1'b1; req_sew = 4'b0001; req_vl = 8'd3;
    step();
    req_valid = 1'b0;
    op_valid = 1'b1; op_data = 64'h0000_0000_0000_0007;
    step();
    op_valid = 1'b0;
    check("t5_pre_valid", res_valid, 1);
    check("t5_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_res_valid", res_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_req_ready", req_ready, 1);
    check("t5_sew", simd_sew, 0);
    req_valid = 1'b1; req_sew = 4'b0100; req_vl = 8'd4;
    step();                                    // T+1
    req_valid = 1'b0;
    op_valid = 1'b1; op_data = 64'h8001_7FFF_FFFF_0001;
    step();                                    // T+2
    op_valid = 1'b0;
    check("t5_data", res_data, 64'h7FFF_7FFF_0001_0001);
    check("t5_be", res_be, 8'hFF);
    check("t5_last", res_last, 1);
    step();                                    // T+3
    check("t5_done", done, 1);

    // ---------------- back-to-back requests, second taken in the done cycle
    req_valid = 1'b1; req_sew = 4'b1000; req_vl = 8'd8;
    step();                                    // T+1
    req_valid = 1'b0;
    op_valid = 1'b1; op_data = 64'h80FE_0102_7F81_FF00;
    step();                                    // T+2
    op_valid = 1'b0;
    check("t6a_data", res_data, 64'h8002_0102_7F7F_0100);
    check("t6a_last", res_last, 1);
    step();                                    // T+3
    check("t6a_done", done, 1);
    check("t6_req_ready_done_cycle", req_ready, 1);
    req_valid = 1'b1; req_vl = 8'd8;
    step();                                    // T'+1
    req_valid = 1'b0;
    check("t6b_busy", busy, 1);
    op_valid = 1'b1; op_data = 64'hF0F0_0F0F_C0C0_3030;
    step();                                    // T'+2
    op_valid = 1'b0;
    check("t6b_valid", res_valid, 1);
    check("t6b_data", res_data, 64'h1010_0F0F_4040_3030);
    check("t6b_be", res_be, 8'hFF);
    check("t6b_last", res_last, 1);
    step();                                    // T'+3
    check("t6b_done", done, 1);
    check("t6b_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/simd_abs_seq.md
# simd_abs_seq

Sequencer that drives one `simd_unsigned` SIMD absolute-value/carry datapath over a whole vector operand. It accepts a request carrying vector length and element width, then streams 64-bit operand words through the datapath at one word per cycle. Results go out on a registered valid/ready port with tail byte-enables. It sits in the vector lane between the operand read port and the lane writeback buffer.

## Interface
- `DATA_WIDTH`, 64: operand/result word width; equals datapath MAX_WIDTH.
- `MIN_WIDTH`, 8: smallest element width.
- `SEW_WIDTH`, $clog2(DATA_WIDTH/MIN_WIDTH)+1 (4): sew field width.
- `VL_WIDTH`, 8: vector length field width, in elements.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_i` in 1 / `req_ready_o` out 1: request handshake.
- `req_vl_i` in VL_WIDTH: element count.
- `req_sew_i` in SEW_WIDTH: one-hot element width. Bit0=64b, bit1=32b, bit2=16b, bit3=8b.
- `op_valid_i` in 1 / `op_ready_o` out 1: operand word handshake.
- `op_data_i` in DATA_WIDTH: operand word.
- `simd_sew_o` out SEW_WIDTH: datapath sew, held at the latched request value.
- `simd_opA_o` out DATA_WIDTH: datapath operand, equal to `op_data_i`.
- `simd_carry_o` out 1: datapath carry_i, constant 0.
- `simd_result_i` in DATA_WIDTH: datapath result (combinational).
- `res_valid_o` out 1 / `res_ready_i` in 1: result handshake.
- `res_data_o` out DATA_WIDTH: registered result.
- `res_be_o` out DATA_WIDTH/MIN_WIDTH: byte enables for live elements.
- `res_last_o` out 1: final beat of the request.
- `done_o` out 1: one-cycle pulse at request completion.
- `err_o` out 1: one-cycle pulse, together with `done_o`, when sew is not one-hot.
- `busy_o` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE**
  - `req_ready_o`=1.
  - On a request handshake, latch sew and vl.
  - epw (elements per word) = 8/4/2/1 for sew bit3/2/1/0.
  - `rem` (remaining-element counter) = vl.
  - If sew is not one-hot or vl=0: stay in IDLE, pulse `done_o` next cycle, and pulse `err_o` too if sew is bad. No beats are issued.
  - Otherwise go to RUN.
- **RUN**
  - `op_ready_o` = !`res_valid_o` || `res_ready_i`. The output register is one-deep with pass-through ready.
  - On an operand handshake:
    - Register `simd_result_i` into `res_data_o`.
    - Set `res_valid_o`.
    - Byte enables = all ones if `rem` > epw, else the low (rem×DATA_WIDTH/8/epw) bytes.
    - `res_last_o` = (`rem` <= epw).
    - `rem` -= min(rem, epw).
  - On the last-beat handshake, go to DRAIN.
- **DRAIN**
  - `op_ready_o`=0.
  - When the last result is accepted: clear `res_valid_o`, go to IDLE, pulse `done_o`.
- Results held while `res_ready_i`=0 stay stable. No operand is consumed in that case.
- Simultaneous result accept and new operand: both occur in the same cycle; the register reloads.
- Reset mid-operation: return to IDLE; all outputs go to reset values; the in-flight word and `rem` are discarded.
- Reset values:
  - `req_ready_o`=1 (IDLE).
  - All other outputs 0.
  - `simd_sew_o` is also 0 in IDLE.

## Timing
- Request accepted in cycle T. `op_ready_o` may first be high in T+1.
- Operand handshake in cycle N gives `res_valid_o` in N+1.
- Throughput is one word per cycle with `res_ready_i` held high.
- A request of B beats with no backpressure:
  - Last result is visible in T+B+1 and accepted there.
  - `done_o` pulses in T+B+2, with IDLE reached the same cycle.
  - The next request can be accepted in T+B+2.
- Empty or illegal request: `done_o` pulses in T+1; `req_ready_o` stays 1.

## Configuration
- `SIMD_ABS_SEQ_ZERO_TAIL_EN`
  - Defined: bytes with `res_be_o`=0 are forced to 0 in `res_data_o`.
  - Undefined: tail bytes carry the raw datapath result; consumers rely on `res_be_o` alone.

## Test plan
- sew=4'b0001, vl=1, operand 0xFFFF_FFFF_FFFF_FFFE -> one beat:
  - data 0x0000_0000_0000_0002, be 0xFF, last=1.
  - done at T+3.
- sew=4'b1000, vl=10, operands 0xFFFF_FFFF_FFFF_FFFF then 0x0000_0000_0000_81FF -> two beats:
  - beat 0: data 0x0101_0101_0101_0101, be 0xFF.
  - beat 1: data 0x0000_0000_0000_7F01 (with ZERO_TAIL), be 0x03, last=1.
- sew=4'b0010, vl=4, `res_ready_i` low for 3 cycles after the first result -> data held stable, `op_ready_o`=0 during the stall, no words lost. Beat 1 has be 0xFF and last=1.
- vl=0 with sew=4'b0100 -> no `op_ready_o`; `done_o`=1, `err_o`=0 at T+1. Then sew=4'b0110, vl=3 -> `done_o`=1 and `err_o`=1 at T+1.
- `rst` asserted in RUN after 1 of 3 beats -> next cycle: IDLE, `res_valid_o`=0, `busy_o`=0, `req_ready_o`=1. A fresh request then completes normally.
- Back-to-back requests, vl=8 with sew=4'b1000 twice -> the second request is accepted in the `done_o` cycle of the first. Result stream is continuous apart from the 1-cycle request gap.
